// File: rtl/mig_ui_pkg.sv
// Shared MIG user-interface definitions: command encodings, scheduler states
// and a width helper for wrapping slot counters.
package mig_ui_pkg;

    typedef enum logic [1:0] {
        CALIB,
        ARB,
        WR_BURST,
        RD_BURST
    } sched_state_t;

    localparam logic [2:0] CMD_WRITE  = 3'b000;
    localparam logic [2:0] CMD_READ   = 3'b001;
    localparam int         APP_ADDR_W = 27;
    localparam int         DATA_W     = 128;
    localparam int         MASK_W     = 16;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_increment.sv
// Wrapping slot counter: counts 0..ROLLOVER-1 on each enabled cycle, then wraps.
module addr_increment
    import mig_ui_pkg::*;
#(
    parameter int ROLLOVER = 2048
)
(
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           i_en,
    output logic [cnt_width(ROLLOVER)-1:0] o_addr
);

    localparam int          W    = cnt_width(ROLLOVER);
    localparam logic [W-1:0] LAST = W'(ROLLOVER - 1);

    logic [W-1:0] r_addr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_addr <= '0;
        else if (i_en)
            r_addr <= (r_addr == LAST) ? '0 : r_addr + W'(1);
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/mig_rw_scheduler.sv
// Round-robin read/write burst scheduler in front of a MIG UI port, using the
// DDR as a ring of 128-bit slots. Optional counters: MIG_RW_SCHED_STATS_EN.
module mig_rw_scheduler
    import mig_ui_pkg::*;
#(
    parameter int MAX_ADDRESS     = 2048,
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 16
)
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [MASK_W-1:0]     app_wdf_mask,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_W-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid,
    input  logic                  init_calib_complete,
    input  logic [DATA_W-1:0]     write_axis_data,
    input  logic                  write_axis_valid,
    output logic                  write_axis_ready,
    output logic [DATA_W-1:0]     read_axis_data,
    output logic                  read_axis_valid,
    output logic                  read_axis_tuser,
    input  logic                  read_axis_ready
`ifdef MIG_RW_SCHED_STATS_EN
    ,
    output logic [31:0]           wr_cmd_count,
    output logic [31:0]           rd_cmd_count,
    output logic [31:0]           stall_count
`endif
);

    localparam int AW = cnt_width(MAX_ADDRESS);
    localparam int FW = $clog2(MAX_ADDRESS + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    localparam logic [FW-1:0] FILL_MAX  = FW'(MAX_ADDRESS);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    sched_state_t  r_state, w_next_state;
    logic          r_last_rd, w_last_rd_next;
    logic [BW-1:0] r_burst_cnt, w_burst_cnt_next;
    logic [FW-1:0] r_fill;
    logic [OW-1:0] r_outstanding;

    logic          w_wr_elig, w_rd_elig;
    logic          w_wr_issue, w_rd_issue, w_issue;
    logic          w_rd_accept;
    logic [AW-1:0] w_wr_addr, w_rd_addr, w_slot;

    assign w_wr_elig = write_axis_valid && app_rdy && app_wdf_rdy && (r_fill < FILL_MAX);
    assign w_rd_elig = read_axis_ready && app_rdy && (r_fill != '0) && (r_outstanding < OUT_MAX);

    assign w_wr_issue = (r_state == WR_BURST) && w_wr_elig;
    assign w_rd_issue = (r_state == RD_BURST) && w_rd_elig;
    assign w_issue    = w_wr_issue || w_rd_issue;

    // Returns with nothing outstanding belong to reads issued before a reset.
    assign w_rd_accept = app_rd_data_valid && (r_outstanding != '0);

    always_comb begin
        w_next_state     = r_state;
        w_last_rd_next   = r_last_rd;
        w_burst_cnt_next = r_burst_cnt;
        case (r_state)
            CALIB: begin
                if (init_calib_complete)
                    w_next_state = ARB;
            end
            ARB: begin
                w_burst_cnt_next = '0;
                if (w_wr_elig && (!w_rd_elig || r_last_rd)) begin
                    w_next_state   = WR_BURST;
                    w_last_rd_next = 1'b0;
                end else if (w_rd_elig) begin
                    w_next_state   = RD_BURST;
                    w_last_rd_next = 1'b1;
                end
            end
            WR_BURST, RD_BURST: begin
                if (w_issue)
                    w_burst_cnt_next = r_burst_cnt + BW'(1);
                if (!w_issue || (w_burst_cnt_next == BURST_MAX)) begin
                    w_next_state     = ARB;
                    w_burst_cnt_next = '0;
                end
            end
            default: w_next_state = CALIB;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= CALIB;
            r_last_rd     <= 1'b0;
            r_burst_cnt   <= '0;
            r_fill        <= '0;
            r_outstanding <= '0;
        end else begin
            r_state     <= w_next_state;
            r_last_rd   <= w_last_rd_next;
            r_burst_cnt <= w_burst_cnt_next;
            if (w_wr_issue)
                r_fill <= r_fill + FW'(1);
            else if (w_rd_issue)
                r_fill <= r_fill - FW'(1);
            if (w_rd_issue && !w_rd_accept)
                r_outstanding <= r_outstanding + OW'(1);
            else if (!w_rd_issue && w_rd_accept)
                r_outstanding <= r_outstanding - OW'(1);
        end
    end

    always_comb begin
        app_en       = 1'b0;
        app_cmd      = '0;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        if (w_wr_issue) begin
            app_en       = 1'b1;
            app_cmd      = CMD_WRITE;
            app_addr     = APP_ADDR_W'(w_wr_addr) << 7;
            app_wdf_data = write_axis_data;
            app_wdf_wren = 1'b1;
            app_wdf_end  = 1'b1;
        end else if (w_rd_issue) begin
            app_en   = 1'b1;
            app_cmd  = CMD_READ;
            app_addr = APP_ADDR_W'(w_rd_addr) << 7;
        end
    end

    assign app_wdf_mask     = '0;
    assign write_axis_ready = w_wr_issue;
    assign read_axis_valid  = w_rd_accept;
    assign read_axis_data   = w_rd_accept ? app_rd_data : '0;
    assign read_axis_tuser  = w_rd_accept && (w_slot == '0);

    addr_increment #(.ROLLOVER(MAX_ADDRESS)) u_wr_addr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_en   (w_wr_issue),
        .o_addr (w_wr_addr)
    );

    addr_increment #(.ROLLOVER(MAX_ADDRESS)) u_rd_addr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_en   (w_rd_issue),
        .o_addr (w_rd_addr)
    );

    // Data returns in issue order, so this tracks the slot of the beat on the bus.
    addr_increment #(.ROLLOVER(MAX_ADDRESS)) u_slot (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_en   (w_rd_accept),
        .o_addr (w_slot)
    );

`ifdef MIG_RW_SCHED_STATS_EN
    logic [31:0] r_wr_cmd_count, r_rd_cmd_count, r_stall_count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_cmd_count <= '0;
            r_rd_cmd_count <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_wr_issue)
                r_wr_cmd_count <= r_wr_cmd_count + 32'd1;
            if (w_rd_issue)
                r_rd_cmd_count <= r_rd_cmd_count + 32'd1;
            if ((r_state == ARB) && write_axis_valid && !w_wr_elig)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign wr_cmd_count = r_wr_cmd_count;
    assign rd_cmd_count = r_rd_cmd_count;
    assign stall_count  = r_stall_count;
`endif

endmodule

// File: tb/tb_mig_rw_scheduler.sv
// Self-checking bench for mig_rw_scheduler: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_mig_rw_scheduler;

    localparam int MA = 2048;
    localparam int BL = 8;
    localparam int MO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, calib, app_rdy, wdf_rdy, rdv, wv, rrdy;
    logic [127:0] rdata, wdata;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, wren, wend, wready, rax_valid, rax_tuser;
    logic [127:0] wdf_data, rax_data;
    logic [15:0]  mask;

    logic         b_calib, b_app_rdy, b_wdf_rdy, b_rdv, b_wv, b_rrdy;
    logic [127:0] b_rdata, b_wdata;
    logic [26:0]  b_app_addr;
    logic [2:0]   b_app_cmd;
    logic         b_app_en, b_wren, b_wend, b_wready, b_rax_valid, b_rax_tuser;
    logic [127:0] b_wdf_data, b_rax_data;
    logic [15:0]  b_mask;

    mig_rw_scheduler #(.MAX_ADDRESS(MA), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)) dut (
        .clk_in(clk), .rst_in(rst),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(wdf_data), .app_wdf_wren(wren), .app_wdf_end(wend), .app_wdf_mask(mask),
        .app_rdy(app_rdy), .app_wdf_rdy(wdf_rdy), .app_rd_data(rdata), .app_rd_data_valid(rdv),
        .init_calib_complete(calib),
        .write_axis_data(wdata), .write_axis_valid(wv), .write_axis_ready(wready),
        .read_axis_data(rax_data), .read_axis_valid(rax_valid), .read_axis_tuser(rax_tuser),
        .read_axis_ready(rrdy)
    );

    mig_rw_scheduler #(.MAX_ADDRESS(4)) dut_small (
        .clk_in(clk), .rst_in(rst),
        .app_addr(b_app_addr), .app_cmd(b_app_cmd), .app_en(b_app_en),
        .app_wdf_data(b_wdf_data), .app_wdf_wren(b_wren), .app_wdf_end(b_wend), .app_wdf_mask(b_mask),
        .app_rdy(b_app_rdy), .app_wdf_rdy(b_wdf_rdy), .app_rd_data(b_rdata), .app_rd_data_valid(b_rdv),
        .init_calib_complete(b_calib),
        .write_axis_data(b_wdata), .write_axis_valid(b_wv), .write_axis_ready(b_wready),
        .read_axis_data(b_rax_data), .read_axis_valid(b_rax_valid), .read_axis_tuser(b_rax_tuser),
        .read_axis_ready(b_rrdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0 calib, 1 arbitrate, 2 write burst, 3 read burst.
    int m_mode, m_cnt, m_wptr, m_rptr, m_fill;
    bit m_last_rd;
    int m_inflight[$];

    // Bench-side MIG read-latency emulation (lat == 0 means caller drives rdv).
    int lat = 0;
    int ret_q[$];
    int cyc = 0;

    logic        o_en, o_wready, o_rvalid;
    logic [2:0]  o_cmd;
    logic [26:0] o_addr;
    int          o_cyc;

    task automatic tick();
        bit we, re, iw, ir, acc, e_tuser;
        if (lat > 0) begin
            rdv   = (ret_q.size() > 0) && (ret_q[0] == cyc);
            rdata = {$urandom, $urandom, $urandom, $urandom};
            if (rdv) void'(ret_q.pop_front());
        end
        #1;
        we  = wv && app_rdy && wdf_rdy && (m_fill < MA);
        re  = rrdy && app_rdy && (m_fill > 0) && (m_inflight.size() < MO);
        iw  = (m_mode == 2) && we;
        ir  = (m_mode == 3) && re;
        acc = rdv && (m_inflight.size() > 0);
        e_tuser = 1'b0;
        if (acc) e_tuser = (m_inflight[0] == 0);

        chk("app_en", app_en, iw || ir);
        chk("app_cmd", app_cmd, ir ? 1 : 0);
        chk("app_addr", app_addr, iw ? m_wptr * 128 : (ir ? m_rptr * 128 : 0));
        chk("wdf_wren_end", {wren, wend}, {iw, iw});
        chk("wdf_data", wdf_data, iw ? wdata : 128'd0);
        chk("wdf_mask", mask, 0);
        chk("wr_ready", wready, iw);
        chk("rd_valid", rax_valid, acc);
        chk("rd_data", rax_data, acc ? rdata : 128'd0);
        chk("rd_tuser", rax_tuser, e_tuser);

        o_en = app_en; o_cmd = app_cmd; o_addr = app_addr;
        o_wready = wready; o_rvalid = rax_valid; o_cyc = cyc;
        if (lat > 0 && app_en && app_cmd == 3'b001) ret_q.push_back(cyc + lat);

        if (acc) void'(m_inflight.pop_front());
        if (ir) m_inflight.push_back(m_rptr);
        if (iw) begin m_wptr = (m_wptr + 1) % MA; m_fill++; end
        if (ir) begin m_rptr = (m_rptr + 1) % MA; m_fill--; end
        case (m_mode)
            0: if (calib) m_mode = 1;
            1: begin
                if (we && (!re || m_last_rd)) begin m_mode = 2; m_last_rd = 1'b0; end
                else if (re) begin m_mode = 3; m_last_rd = 1'b1; end
            end
            default: begin
                if (iw || ir) m_cnt++;
                if (!(iw || ir) || m_cnt == BL) begin m_mode = 1; m_cnt = 0; end
            end
        endcase
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_mode = 0; m_cnt = 0; m_wptr = 0; m_rptr = 0; m_fill = 0; m_last_rd = 1'b0;
        m_inflight.delete();
        ret_q.delete();
        lat = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        calib = 0; app_rdy = 1; wdf_rdy = 1; rdv = 0; wv = 0; rrdy = 0; rdata = '0; wdata = '0;
        b_calib = 0; b_app_rdy = 1; b_wdf_rdy = 1; b_rdv = 0; b_wv = 0; b_rrdy = 0;
        b_rdata = '0; b_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        model_clear();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         calib, wv, rdy, rrdy;
        bit         en;
        logic [2:0] cmd;
        int         addr;
        bit         wready;
    } vec_t;
    vec_t tbl[10];

    int wc[$], wa[$], runs[$], gaps[$], rtype[$], seq[$], rdc[$];
    int n, fl, viol, sent, tret, first_after, pre;
    bit seen, got;

    initial begin
        // calib, wv, app_rdy, rrdy -> en, cmd, addr, wready
        tbl[0] = '{0, 1, 1, 1, 0, 3'd0,   0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 3'd0,   0, 0};
        tbl[2] = '{1, 1, 1, 1, 0, 3'd0,   0, 0};
        tbl[3] = '{1, 1, 1, 1, 1, 3'd0,   0, 1};
        tbl[4] = '{1, 1, 0, 1, 0, 3'd0,   0, 0};
        tbl[5] = '{1, 1, 1, 1, 0, 3'd0,   0, 0};
        tbl[6] = '{1, 1, 1, 1, 1, 3'd1,   0, 0};
        tbl[7] = '{1, 1, 1, 1, 0, 3'd0,   0, 0};
        tbl[8] = '{1, 1, 1, 1, 0, 3'd0,   0, 0};
        tbl[9] = '{1, 1, 1, 1, 1, 3'd0, 128, 1};

        // Reset state, with read data arriving during reset.
        rst = 1'b1;
        calib = 0; app_rdy = 1; wdf_rdy = 1; rdv = 1; wv = 1; rrdy = 1;
        rdata = 128'hdead; wdata = 128'hbeef;
        b_calib = 0; b_app_rdy = 1; b_wdf_rdy = 1; b_rdv = 0; b_wv = 0; b_rrdy = 0;
        b_rdata = '0; b_wdata = '0;
        @(negedge clk);
        #1;
        chk("reset_cmd_outs", {app_en, app_cmd, app_addr, wren, wend}, 0);
        chk("reset_wready", wready, 0);
        chk("reset_rd_outs", {rax_valid, rax_tuser, rax_data}, 0);
        do_reset();

        // Vector table from reset.
        for (int i = 0; i < 10; i++) begin
            calib = tbl[i].calib; wv = tbl[i].wv; app_rdy = tbl[i].rdy; rrdy = tbl[i].rrdy;
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk($sformatf("tbl%0d_en", i), o_en, tbl[i].en);
            chk($sformatf("tbl%0d_cmd", i), o_cmd, tbl[i].cmd);
            chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_wready", i), o_wready, tbl[i].wready);
        end

        // A read is in flight; its data after reset must be dropped.
        do_reset();
        calib = 1; rdv = 1; rdata = 128'h1234;
        tick();
        chk("stale_rd_dropped", o_rvalid, 0);
        rdv = 0;

        // Calibration hold.
        do_reset();
        calib = 0; wv = 1; rrdy = 1; seen = 0;
        for (int i = 0; i < 100; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (o_en || o_wready) seen = 1;
        end
        chk("calib_quiet", seen, 0);

        // Write-only, 20 words.
        do_reset();
        calib = 1; rrdy = 0; sent = 0;
        wc.delete(); wa.delete();
        for (int i = 0; i < 100 && (sent < 20 || i < 40); i++) begin
            wv = (sent < 20);
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (o_en) begin wc.push_back(o_cyc); wa.push_back(int'(o_addr)); end
            if (o_wready) sent++;
        end
        chk("wo_count", wc.size(), 20);
        foreach (wa[k]) chk($sformatf("wo_addr%0d", k), wa[k], k * 128);
        runs.delete(); gaps.delete(); n = 1;
        for (int k = 1; k < wc.size(); k++) begin
            if (wc[k] == wc[k-1] + 1) n++;
            else begin runs.push_back(n); gaps.push_back(wc[k] - wc[k-1]); n = 1; end
        end
        if (wc.size() > 0) runs.push_back(n);
        chk("wo_burst_count", runs.size(), 3);
        if (runs.size() == 3) begin
            chk("wo_burst0", runs[0], 8);
            chk("wo_burst1", runs[1], 8);
            chk("wo_burst2", runs[2], 4);
            chk("wo_gap0", gaps[0], 2);
            chk("wo_gap1", gaps[1], 2);
        end

        // Both sides saturated.
        do_reset();
        calib = 1; wv = 1; rrdy = 1; lat = 3;
        seq.delete(); fl = 0; viol = 0;
        for (int i = 0; i < 80; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (o_en) begin
                if (o_cmd == 3'b001) begin
                    if (fl == 0) viol++;
                    fl--; seq.push_back(1);
                end else begin
                    fl++; seq.push_back(0);
                end
            end
        end
        chk("sat_no_read_empty", viol, 0);
        runs.delete(); rtype.delete(); n = 1;
        for (int k = 1; k < seq.size(); k++) begin
            if (seq[k] == seq[k-1]) n++;
            else begin runs.push_back(n); rtype.push_back(seq[k-1]); n = 1; end
        end
        chk("sat_enough_runs", runs.size() >= 4, 1);
        if (runs.size() > 0) chk("sat_first_is_write", rtype[0], 0);
        foreach (runs[k]) begin
            chk($sformatf("sat_run%0d_len", k), runs[k], 8);
            if (k > 0) chk($sformatf("sat_run%0d_alt", k), rtype[k], 1 - rtype[k-1]);
        end

        // Read latency 40: issue stops at 16 outstanding.
        do_reset();
        calib = 1; rrdy = 0; wv = 1; sent = 0;
        for (int i = 0; i < 60 && sent < 24; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (o_wready) sent++;
        end
        chk("lat_prefill", sent, 24);
        wv = 0; rrdy = 1; lat = 40; tret = -1; rdc.delete();
        for (int i = 0; i < 120; i++) begin
            tick();
            if (o_en && o_cmd == 3'b001) rdc.push_back(o_cyc);
            if (rdv && tret < 0) tret = o_cyc;
        end
        chk("lat_return_seen", tret >= 0, 1);
        pre = 0; first_after = -1;
        foreach (rdc[k]) begin
            if (rdc[k] <= tret) pre++;
            else if (first_after < 0) first_after = rdc[k];
        end
        chk("lat_reads_before_return", pre, 16);
        chk("lat_resume_cycle", first_after, tret + 2);

        // MAX_ADDRESS = 4 ring.
        do_reset();
        b_calib = 1; b_wv = 1; b_rrdy = 0;
        wa.delete(); seen = 0;
        for (int i = 0; i < 20; i++) begin
            b_wdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (b_app_en && b_app_cmd == 3'b000) begin
                if (wa.size() < 4) wa.push_back(int'(b_app_addr));
                else seen = 1;
            end
            if (wa.size() == 4 && b_wready && b_app_en == 1'b0) seen = 1;
            @(negedge clk);
        end
        chk("ring_first_writes", wa.size(), 4);
        foreach (wa[k]) chk($sformatf("ring_addr%0d", k), wa[k], k * 128);
        chk("ring_full_stall", seen, 0);
        b_rrdy = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (b_app_en) begin
                chk("ring_read_before_write", b_app_cmd, 3'b001);
                chk("ring_read_addr", b_app_addr, 0);
                got = 1;
            end
            @(negedge clk);
        end
        chk("ring_read_issued", got, 1);
        b_rrdy = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (b_app_en) begin
                chk("ring_fifth_cmd", b_app_cmd, 3'b000);
                chk("ring_fifth_addr", b_app_addr, 0);
                got = 1;
            end
            @(negedge clk);
        end
        chk("ring_fifth_issued", got, 1);
        b_wv = 0; b_rdv = 1; b_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("ring_rd_valid", b_rax_valid, 1);
        chk("ring_tuser_slot0", b_rax_tuser, 1);
        chk("ring_rd_data", b_rax_data, b_rdata);
        @(negedge clk);
        b_rdv = 0;

        // Reset mid write burst.
        do_reset();
        calib = 1; wv = 1; rrdy = 0;
        for (int i = 0; i < 4; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        #1;
        chk("midrst_in_burst", app_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cmd_zero", {app_en, app_cmd, app_addr, wren, wend, wdf_data}, 0);
        chk("midrst_wready_zero", wready, 0);
        @(negedge clk);
        model_clear();
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (o_en) begin chk("midrst_first_addr", o_addr, 0); got = 1; end
        end
        chk("midrst_write_seen", got, 1);

        // Randomized traffic against the model.
        do_reset();
        calib = 1;
        for (int i = 0; i < 500; i++) begin
            wv      = ($urandom_range(0, 3) != 0);
            rrdy    = ($urandom_range(0, 3) != 0);
            app_rdy = ($urandom_range(0, 6) != 0);
            wdf_rdy = ($urandom_range(0, 6) != 0);
            rdv     = ($urandom_range(0, 2) == 0);
            rdata   = {$urandom, $urandom, $urandom, $urandom};
            wdata   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
